// File: rtl/uart_rx_8n1.sv
// UART receiver, 8 data bits, no parity, one stop bit.
// The line is double-flopped, then a single FSM times each bit from the
// falling edge of the start bit. Received bytes and framing errors are
// reported as registered one-cycle pulses.
`timescale 1ns/1ps

module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_serial_i,
  output logic       rx_dv_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_frame_err_o
);

  // Counter only has to reach CLKS_PER_BIT-1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_t;

  logic          sync_meta;
  logic          sync_line;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;

  // Two-flop synchronizer; resets to the idle (high) level so that reset
  // release never looks like a start edge on an idle line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
    end else begin
      sync_meta <= rx_serial_i;
      sync_line <= sync_meta;
    end
  end

  // Receive FSM with registered byte, data-valid and framing-error outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      shift          <= '0;
      rx_dv_o        <= 1'b0;
      rx_frame_err_o <= 1'b0;
      rx_byte_o      <= '0;
    end else begin
      // Pulses last one cycle unless re-asserted below.
      rx_dv_o        <= 1'b0;
      rx_frame_err_o <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!sync_line) begin
            state <= S_START;
          end
        end

        S_START: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (cnt == MID_CNT) begin
            if (!sync_line) begin
              cnt   <= '0;
              idx   <= '0;
              state <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          // Mid-start plus one full bit lands in the middle of each data bit.
          if (cnt == LAST_CNT) begin
            cnt        <= '0;
            shift[idx] <= sync_line;
            if (idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (sync_line) begin
              rx_byte_o <= shift;
              rx_dv_o   <= 1'b1;
            end else begin
              rx_frame_err_o <= 1'b1;
            end
            state <= S_CLEANUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_CLEANUP: begin
          // Wait for the line to return high so a held break cannot retrigger.
          if (sync_line) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: a serial line driver, a byte-queue model
// of what must come out, and a per-cycle compare process on the outputs.
`timescale 1ns/1ps

module tb_uart_rx_8n1;

  localparam int CPB      = 217;
  localparam int CLK_NS   = 40;
  localparam int BIT_NS   = CPB * CLK_NS;   // 8680 ns
  localparam int CPB_S    = 4;
  localparam int BIT_NS_S = CPB_S * CLK_NS; // 160 ns

  logic       clk;
  logic       rst;
  logic       rx;
  logic       dv;
  logic [7:0] rx_byte;
  logic       ferr;
  logic       rx_s;
  logic       dv_s;
  logic [7:0] rx_byte_s;
  logic       ferr_s;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model state: bytes that must appear, in order, and the byte that must be held.
  logic [7:0] exp_q[$];
  logic [7:0] model_byte = 8'h00;
  int dv_cnt    = 0;
  int err_cnt   = 0;
  int dv_cnt_s  = 0;
  int err_cnt_s = 0;
  logic [7:0] last_byte_s = 8'h00;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_serial_i    (rx),
    .rx_dv_o        (dv),
    .rx_byte_o      (rx_byte),
    .rx_frame_err_o (ferr)
  );

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB_S)) dut_small (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_serial_i    (rx_s),
    .rx_dv_o        (dv_s),
    .rx_byte_o      (rx_byte_s),
    .rx_frame_err_o (ferr_s)
  );

  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_line(input bit to_small, input logic v);
    if (to_small) rx_s = v;
    else          rx   = v;
  endtask

  // Drive one 8N1 frame; stop_val=0 forces a framing error, extra_ns stretches the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int extra_ns,
                            input int bit_ns, input bit to_small);
    set_line(to_small, 1'b0);
    #(bit_ns + extra_ns);
    for (int i = 0; i < 8; i++) begin
      set_line(to_small, b[i]);
      #(bit_ns);
    end
    set_line(to_small, stop_val);
    #(bit_ns);
    set_line(to_small, 1'b1);
    $display("frame sent: byte=0x%02h stop=%0d stretch=%0dns bit=%0dns line=%s",
             b, stop_val, extra_ns, bit_ns, to_small ? "small" : "main");
  endtask

  task automatic idle_clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare process: every cycle, the main receiver's outputs must agree with the model.
  always @(negedge clk) begin
    if (rst) begin
      chk(!dv && !ferr && rx_byte == 8'h00, "reset_outputs", {dv, ferr, rx_byte}, 32'h0);
      model_byte = 8'h00;
    end else begin
      chk(!(dv && ferr), "dv_err_exclusive", {dv, ferr}, 32'h0);
      if (dv) begin
        dv_cnt++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_dv", rx_byte, 32'h0);
        end else begin
          model_byte = exp_q.pop_front();
          chk(rx_byte == model_byte, "rx_byte_on_dv", rx_byte, model_byte);
        end
      end else begin
        chk(rx_byte == model_byte, "rx_byte_hold", rx_byte, model_byte);
      end
      if (ferr) err_cnt++;
      if (dv_s) begin
        dv_cnt_s++;
        last_byte_s = rx_byte_s;
      end
      if (ferr_s) err_cnt_s++;
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #3ms;
    $display("FAIL timeout: actual=%0t required=<3ms", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "time limit");
  end

  initial begin
    rst  = 1'b1;
    rx   = 1'b1;
    rx_s = 1'b1;
    idle_clocks(4);
    #1;
    chk(dv == 1'b0 && ferr == 1'b0, "reset_pulses", {dv, ferr}, 32'h0);
    chk(rx_byte == 8'h00, "reset_byte", rx_byte, 32'h00);
    chk(rx_byte_s == 8'h00 && dv_s == 1'b0 && ferr_s == 1'b0, "reset_small", {dv_s, ferr_s, rx_byte_s}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_clocks(10);

    // Basic byte with a start bit stretched by 1000 ns.
    exp_q.push_back(8'hAB);
    send_frame(8'hAB, 1'b1, 1000, BIT_NS, 1'b0);
    idle_clocks(20);
    chk(dv_cnt == 1, "basic_dv_count", dv_cnt, 1);
    chk(rx_byte == 8'hAB, "basic_byte", rx_byte, 32'hAB);

    // Back-to-back frames, no idle between stop and next start.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1, 0, BIT_NS, 1'b0);
    send_frame(8'hFF, 1'b1, 0, BIT_NS, 1'b0);
    send_frame(8'h55, 1'b1, 0, BIT_NS, 1'b0);
    idle_clocks(20);
    chk(dv_cnt == 4, "b2b_dv_count", dv_cnt, 4);
    chk(rx_byte == 8'h55, "b2b_last_byte", rx_byte, 32'h55);

    // Glitch: 50 clocks low is shorter than half a bit, so it is rejected.
    rx = 1'b0;
    idle_clocks(50);
    rx = 1'b1;
    $display("glitch sent: 50 clocks low");
    idle_clocks(3 * CPB);
    chk(dv_cnt == 4, "glitch_no_dv", dv_cnt, 4);
    chk(err_cnt == 0, "glitch_no_err", err_cnt, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 0, BIT_NS, 1'b0);
    idle_clocks(20);
    chk(rx_byte == 8'h3C, "after_glitch_byte", rx_byte, 32'h3C);

    // Framing error: stop bit low, byte output must keep 0x3C.
    send_frame(8'h81, 1'b0, 0, BIT_NS, 1'b0);
    idle_clocks(2 * CPB);
    chk(err_cnt == 1, "ferr_count", err_cnt, 1);
    chk(dv_cnt == 5, "ferr_no_dv", dv_cnt, 5);
    chk(rx_byte == 8'h3C, "ferr_byte_kept", rx_byte, 32'h3C);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 0, BIT_NS, 1'b0);
    idle_clocks(20);
    chk(rx_byte == 8'h42, "after_ferr_byte", rx_byte, 32'h42);

    // Reset in the middle of data bit 4 of 0xA5; held until the line is idle again.
    fork
      send_frame(8'hA5, 1'b1, 0, BIT_NS, 1'b0);
      begin
        #(5 * BIT_NS + BIT_NS / 2 + 10);
        rst = 1'b1;
        #1;
        chk(dv == 1'b0 && ferr == 1'b0 && rx_byte == 8'h00, "reset_midframe_outputs",
            {dv, ferr, rx_byte}, 32'h0);
      end
    join
    idle_clocks(10);
    @(negedge clk);
    rst = 1'b0;
    idle_clocks(3 * CPB);
    chk(dv_cnt == 6, "reset_no_dv", dv_cnt, 6);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 0, BIT_NS, 1'b0);
    idle_clocks(20);
    chk(rx_byte == 8'h5A, "after_reset_byte", rx_byte, 32'h5A);
    chk(dv_cnt == 7, "after_reset_dv_count", dv_cnt, 7);

    // Minimum bit period on the second instance.
    idle_clocks(3);
    send_frame(8'hC3, 1'b1, 0, BIT_NS_S, 1'b1);
    idle_clocks(20);
    chk(dv_cnt_s == 1, "small_dv_count", dv_cnt_s, 1);
    chk(last_byte_s == 8'hC3 && rx_byte_s == 8'hC3, "small_byte", rx_byte_s, 32'hC3);
    chk(err_cnt_s == 0, "small_no_err", err_cnt_s, 0);

    chk(exp_q.size() == 0, "all_expected_received", exp_q.size(), 0);
    chk(err_cnt == 1, "total_err_count", err_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 217, is the clock cycles per serial bit (25 MHz / 115200 baud); legal range 4..65535.
REQ-002 Port: clk_i, input, 1, is the single system clock; all logic is on its rising edge.
REQ-003 Port: rst_i, input, 1, is an asynchronous active-high reset.
REQ-004 Port: rx_serial_i, input, 1, is the asynchronous UART line; it idles high.
REQ-005 Port: rx_dv_o, output, 1, is a one-cycle pulse marking a new valid byte on rx_byte_o.
REQ-006 Port: rx_byte_o, output, 8, is the last correctly framed received byte.
REQ-007 Port: rx_frame_err_o, output, 1, is a one-cycle pulse when the stop bit samples low.

Function
REQ-008 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, no parity, one stop bit (1).
REQ-009 rx_serial_i SHALL pass through a 2-flop synchronizer, reset value 1; all decisions use the synchronized signal.
REQ-010 The FSM SHALL have states IDLE, START, DATA, STOP, CLEANUP, and one cycle-counter sized for CLKS_PER_BIT-1.
REQ-011 In IDLE, the counter is held at 0; a synchronized low moves the FSM to START.
REQ-012 In START, the counter counts to (CLKS_PER_BIT-1)/2 (integer division; 108 at default) to reach mid-bit.
- If the line is still low there: clear the counter, clear the bit index, go to DATA.
- If the line is high (glitch): return to IDLE with no output activity.
REQ-013 In DATA, the counter counts to CLKS_PER_BIT-1, then samples the line into shift-register bit [index] (index 0..7, LSB first) and clears the counter.
- After index 7 the FSM goes to STOP; otherwise the index increments.
REQ-014 In STOP, after CLKS_PER_BIT-1 counts, the stop bit is sampled.
- High: load rx_byte_o from the shift register and pulse rx_dv_o for exactly one cycle.
- Low: leave rx_byte_o unchanged, pulse rx_frame_err_o for one cycle, and assert no rx_dv_o.
- Either way, go to CLEANUP.
REQ-015 CLEANUP SHALL last at least one cycle and return to IDLE only once the synchronized line is high, so a held-low break causes no re-triggering.
REQ-016 rx_dv_o and rx_frame_err_o SHALL never be high in the same cycle and SHALL be registered outputs.
REQ-017 rx_byte_o SHALL hold its value between frames; it changes only in the cycle that rx_dv_o rises.
REQ-018 A new start bit SHALL be accepted on the first IDLE cycle after CLEANUP, so back-to-back frames with zero idle time are received.
REQ-019 Start-bit tolerance: a start bit lengthened by up to 0.4 bit period SHALL still decode correctly, because sampling is anchored to the falling edge.

Reset
REQ-020 While rst_i is high:
- FSM = IDLE, counter = 0, bit index = 0, shift register = 0x00;
- synchronizer flops = 1;
- rx_dv_o = 0, rx_frame_err_o = 0, rx_byte_o = 0x00.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no rx_dv_o pulse.
REQ-022 After reset release, reception SHALL restart only on a fresh high-to-low transition.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Basic byte: CLKS_PER_BIT=217, 40 ns clock; send 0xAB (bit time 8680 ns, start bit stretched by 1000 ns) -> single rx_dv_o pulse, rx_byte_o=0xAB.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap -> three rx_dv_o pulses carrying 0x00, 0xFF, 0x55 in order.
- Glitch: drive the line low for 50 clocks, then high -> no rx_dv_o, no rx_frame_err_o; a following 0x3C is received correctly.
- Framing error: send 0x81 with the stop bit low, then release the line high -> rx_frame_err_o pulses once, no rx_dv_o, rx_byte_o keeps its previous value; the next 0x42 is received.
- Reset mid-frame: assert rst_i during data bit 4 of 0xA5 -> outputs go to 0 immediately, no rx_dv_o; a later 0x5A is received correctly.
- Small parameter: CLKS_PER_BIT=4; send 0xC3 -> rx_byte_o=0xC3, exactly one rx_dv_o pulse.
